// File: rtl/rf_wport_arbiter.sv
// Single regfile write-port arbiter: writeback (WB) requests vs. a 2-entry FIFO of long-latency
// unit (LU) writes, registered output, decode hazard detect. RF_ARB_STARVE_GUARD_EN adds LU anti-starvation.
module rf_wport_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_valid,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        wb_ready,
   input  logic        lu_valid,
   input  logic [4:0]  lu_rd,
   input  logic [31:0] lu_data,
   output logic        lu_ready,
   output logic        rf_w_en,
   output logic [4:0]  rf_rd_id,
   output logic [31:0] rf_wdata,
   input  logic [4:0]  rs1_id,
   input  logic [4:0]  rs2_id,
   output logic        hazard
);

   logic [4:0]  r_fifo_rd   [2];
   logic [31:0] r_fifo_data [2];
   logic        r_wptr;
   logic        r_rptr;
   logic [1:0]  r_count;

   logic        r_rf_w_en;
   logic [4:0]  r_rf_rd_id;
   logic [31:0] r_rf_wdata;

   logic        w_nonempty;
   logic        w_push;
   logic        w_pop;
   logic        w_force;
   logic        w_wb_grant;
   logic        w_win;
   logic [4:0]  w_win_rd;
   logic [31:0] w_win_data;
   logic [1:0]  w_entry_valid;
   logic [1:0]  w_entry_hit;
   logic        w_out_hit;
   logic        w_rs1_nz;
   logic        w_rs2_nz;

   assign w_nonempty = (r_count != 2'd0);
   // Ready comes from the registered count only, so a full FIFO never accepts even while popping.
   assign lu_ready   = (r_count != 2'd2);
   assign w_push     = lu_valid & lu_ready;
   assign wb_ready   = ~w_force;
   assign w_wb_grant = wb_valid & wb_ready;
   assign w_pop      = w_nonempty & (~wb_valid | w_force);

   // WB grant and FIFO pop are mutually exclusive by construction.
   assign w_win      = w_wb_grant | w_pop;
   assign w_win_rd   = w_wb_grant ? wb_rd   : r_fifo_rd[r_rptr];
   assign w_win_data = w_wb_grant ? wb_data : r_fifo_data[r_rptr];

`ifdef RF_ARB_STARVE_GUARD_EN
   logic [3:0] r_starve_cnt;
   logic       r_force;

   assign w_force = r_force & w_nonempty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_starve_cnt <= 4'd0;
         r_force      <= 1'b0;
      end else if (!w_nonempty || w_pop) begin
         r_starve_cnt <= 4'd0;
         r_force      <= 1'b0;
      end else if (r_starve_cnt == 4'(STARVE_LIMIT - 1)) begin
         r_starve_cnt <= 4'd0;
         r_force      <= 1'b1;
      end else begin
         r_starve_cnt <= r_starve_cnt + 4'd1;
      end
   end
`else
   logic [3:0] w_unused_limit;

   // Strict WB priority: the starvation limit has no effect in this build.
   assign w_force        = 1'b0;
   assign w_unused_limit = 4'(STARVE_LIMIT);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= 2'd0;
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
      end else begin
         if (w_push) r_wptr <= ~r_wptr;
         if (w_pop)  r_rptr <= ~r_rptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_rd[r_wptr]   <= lu_rd;
         r_fifo_data[r_wptr] <= lu_data;
      end
   end

   // x0 writes complete their handshake but never reach the regfile.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rf_w_en  <= 1'b0;
         r_rf_rd_id <= 5'd0;
         r_rf_wdata <= 32'd0;
      end else begin
         r_rf_w_en <= w_win & (w_win_rd != 5'd0);
         if (w_win) begin
            r_rf_rd_id <= w_win_rd;
            r_rf_wdata <= w_win_data;
         end
      end
   end

   assign rf_w_en  = r_rf_w_en;
   assign rf_rd_id = r_rf_rd_id;
   assign rf_wdata = r_rf_wdata;

   assign w_rs1_nz = (rs1_id != 5'd0);
   assign w_rs2_nz = (rs2_id != 5'd0);

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_entry
         assign w_entry_valid[gi] = (r_count == 2'd2) ||
                                    ((r_count == 2'd1) && (r_rptr == 1'(gi)));
         assign w_entry_hit[gi]   = w_entry_valid[gi] &&
                                    ((w_rs1_nz && (rs1_id == r_fifo_rd[gi])) ||
                                     (w_rs2_nz && (rs2_id == r_fifo_rd[gi])));
      end
   endgenerate

   assign w_out_hit = r_rf_w_en &&
                      ((w_rs1_nz && (rs1_id == r_rf_rd_id)) ||
                       (w_rs2_nz && (rs2_id == r_rf_rd_id)));
   assign hazard    = (|w_entry_hit) | w_out_hit;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter: expected regfile writes go into a queue that a negedge
// monitor drains; handshake/hazard outputs are checked inline. Works with or without the guard macro.
module tb_rf_wport_arbiter;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_ready;
   logic        lu_valid;
   logic [4:0]  lu_rd;
   logic [31:0] lu_data;
   logic        lu_ready;
   logic        rf_w_en;
   logic [4:0]  rf_rd_id;
   logic [31:0] rf_wdata;
   logic [4:0]  rs1_id;
   logic [4:0]  rs2_id;
   logic        hazard;

   int  n_checks = 0;
   int  n_errors = 0;
   wr_t exp_q[$];
   wr_t mon_e;

   always #5 clk = ~clk;

   rf_wport_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
      .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
      .rf_w_en(rf_w_en), .rf_rd_id(rf_rd_id), .rf_wdata(rf_wdata),
      .rs1_id(rs1_id), .rs2_id(rs2_id), .hazard(hazard)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
      wb_valid = wv;  wb_rd = wrd;  wb_data = wd;
      lu_valid = lv;  lu_rd = lrd;  lu_data = ld;
      #1;
   endtask

   task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
      wr_t e;
      e.rd   = rd;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Monitor: every regfile write must match the oldest expected write.
   always @(negedge clk) begin
      if (rf_w_en === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_write: got rd=%0d data=0x%0h, required no write", rf_rd_id, rf_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            if (rf_rd_id !== mon_e.rd || rf_wdata !== mon_e.data) begin
               n_errors++;
               $display("FAIL write_order: got rd=%0d data=0x%0h, required rd=%0d data=0x%0h",
                        rf_rd_id, rf_wdata, mon_e.rd, mon_e.data);
            end else begin
               $display("write rd=%0d data=0x%0h ok", rf_rd_id, rf_wdata);
            end
         end
      end
   end

   initial begin
      #100000;
      n_errors++;
      $display("FAIL watchdog: got timeout, required completion");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0;
      rs1_id = 5'd0;
      rs2_id = 5'd0;
      drive(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_wb_ready", wb_ready, 1);
      check("rst_lu_ready", lu_ready, 1);
      check("rst_hazard", hazard, 0);
      check("rst_rf_w_en", rf_w_en, 0);
      check("rst_rf_rd_id", rf_rd_id, 0);
      check("rst_rf_wdata", rf_wdata, 0);
      rst = 1'b1;

      // WB write to x5, then a suppressed x0 write
      drive(1, 5, 32'h1234, 0, 0, 0);
      check("wb5_ready", wb_ready, 1);
      expect_wr(5, 32'h1234);
      tick();
      check("wb5_rf_w_en", rf_w_en, 1);
      check("wb5_rf_rd_id", rf_rd_id, 5);
      drive(1, 0, 32'hFFFF, 0, 0, 0);
      check("x0_wb_ready", wb_ready, 1);
      tick();
      check("x0_rf_w_en", rf_w_en, 0);
      drive(0, 0, 0, 0, 0, 0);
      tick();

      // Three LU pushes under continuous WB traffic
      drive(1, 20, 32'h20, 1, 1, 32'h101);
      check("luA_ready", lu_ready, 1);
      expect_wr(20, 32'h20);
      tick();
      drive(1, 21, 32'h21, 1, 2, 32'h102);
      check("luB_ready", lu_ready, 1);
      expect_wr(21, 32'h21);
      tick();
      drive(1, 22, 32'h22, 1, 3, 32'h103);
      check("luC_full", lu_ready, 0);
      check("luC_wb_ready", wb_ready, 1);
      expect_wr(22, 32'h22);
      tick();
      drive(1, 23, 32'h23, 1, 3, 32'h103);
      check("luD_full", lu_ready, 0);
      expect_wr(23, 32'h23);
      tick();
      drive(0, 0, 0, 1, 3, 32'h103);
      check("luE_full_pop", lu_ready, 0);
      expect_wr(1, 32'h101);
      tick();
      drive(0, 0, 0, 1, 3, 32'h103);
      check("luF_push_pop", lu_ready, 1);
      expect_wr(2, 32'h102);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      expect_wr(3, 32'h103);
      tick();
      tick();

      // Hazard against a FIFO entry and against the output register
      drive(1, 10, 32'h10, 1, 9, 32'h99);
      expect_wr(10, 32'h10);
      tick();
      drive(1, 11, 32'h11, 0, 0, 0);
      expect_wr(11, 32'h11);
      rs1_id = 9;  rs2_id = 0;  #1;
      check("haz_fifo_rs1", hazard, 1);
      rs1_id = 0;  rs2_id = 10; #1;
      check("haz_out_rs2", hazard, 1);
      rs1_id = 0;  rs2_id = 0;  #1;
      check("haz_zero", hazard, 0);
      rs1_id = 12; rs2_id = 13; #1;
      check("haz_nomatch", hazard, 0);
      rs1_id = 0;  rs2_id = 0;
      tick();
      drive(0, 0, 0, 0, 0, 0);
      rs1_id = 11; #1;
      check("haz_out_rs1", hazard, 1);
      rs1_id = 0;
      expect_wr(9, 32'h99);
      tick();
      tick();

      // FIFO holding x7 against a WB stream
      drive(1, 14, 32'h14, 1, 7, 32'h77);
      expect_wr(14, 32'h14);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(1, 5'(15 + i), 32'(15 + i), 0, 0, 0);
         check("lost_wb_ready", wb_ready, 1);
         expect_wr(5'(15 + i), 32'(15 + i));
         tick();
      end
      drive(1, 19, 32'h19, 0, 0, 0);
`ifdef RF_ARB_STARVE_GUARD_EN
      check("force_wb_ready", wb_ready, 0);
      expect_wr(7, 32'h77);
      tick();
      drive(1, 19, 32'h19, 0, 0, 0);
      check("after_force_wb_ready", wb_ready, 1);
      expect_wr(19, 32'h19);
      tick();
`else
      check("strict_wb_ready", wb_ready, 1);
      expect_wr(19, 32'h19);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      check("strict_drain_wb_ready", wb_ready, 1);
      expect_wr(7, 32'h77);
      tick();
`endif
      drive(0, 0, 0, 0, 0, 0);
      tick();
      tick();

      // Reset asserted mid-operation with the FIFO full
      drive(1, 21, 32'h21, 1, 25, 32'h25);
      expect_wr(21, 32'h21);
      tick();
      drive(1, 22, 32'h22, 1, 26, 32'h26);
      expect_wr(22, 32'h22);
      tick();
      drive(1, 23, 32'h23, 0, 0, 0);
      rs1_id = 25; #1;
      check("pre_rst_full", lu_ready, 0);
      check("pre_rst_hazard", hazard, 1);
      @(negedge clk);
      #1;
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      check("mid_rst_lu_ready", lu_ready, 1);
      check("mid_rst_wb_ready", wb_ready, 1);
      check("mid_rst_hazard", hazard, 0);
      check("mid_rst_rf_w_en", rf_w_en, 0);
      rs1_id = 0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (4) tick();
      check("post_rst_lu_ready", lu_ready, 1);
      drive(1, 5, 32'hBEEF, 0, 0, 0);
      expect_wr(5, 32'hBEEF);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      tick();
      tick();

      check("queue_drained", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
